// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: fetch port, data port and the memory command/response bus.
// The arbiter connects through the slave modport; the pipeline/memory side uses master.
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ack;
    logic              dm_req;
    logic              dm_wr;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_ack;
    logic              mem_en;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    modport slave (
        input  if_req, if_addr, dm_req, dm_wr, dm_addr, dm_wdata, mem_rdata,
        output if_rdata, if_ack, dm_rdata, dm_ack,
        output mem_en, mem_wr, mem_addr, mem_wdata, busy
    );

    modport master (
        output if_req, if_addr, dm_req, dm_wr, dm_addr, dm_wdata, mem_rdata,
        input  if_rdata, if_ack, dm_rdata, dm_ack,
        input  mem_en, mem_wr, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one fixed-latency memory between the fetch port (reads only)
// and the data port (reads/writes). The data port wins ties since it carries the
// older instruction. Each access runs IDLE -> ISSUE -> WAIT -> RESP and returns a
// one-cycle ack to its owner.
// Optional build macro: ARB_STARVE_GUARD_EN -- after STARVE_LIMIT consecutive data
// grants taken while fetch waits, the next grant is forced to fetch.
module mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int LATENCY = 4
`ifdef ARB_STARVE_GUARD_EN
    ,
    parameter int STARVE_LIMIT = 3
`endif
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);

    localparam int CNT_W = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic              owner_dm_q, owner_dm_d;   // 1 = data port owns the transaction
    logic              wr_q, wr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;   // doubles as the latched grant address
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d; // doubles as the latched write data
    logic              grant_dm;
    logic              any_req;
    logic              resp_fire;
    logic [DATA_W-1:0] resp_data;

    assign any_req = bus.if_req | bus.dm_req;

`ifdef ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    logic [SW-1:0] starve_q, starve_d;

    // Winner: data port, unless fetch has already waited through STARVE_LIMIT data grants.
    always_comb begin
        grant_dm = bus.dm_req;
        if (bus.if_req && (starve_q >= SW'(STARVE_LIMIT))) begin
            grant_dm = 1'b0;
        end
    end

    // Count data grants made while fetch waits; any other grant restarts the streak.
    always_comb begin
        starve_d = starve_q;
        if ((state_q == IDLE) && any_req) begin
            if (grant_dm && bus.if_req) begin
                starve_d = starve_q + 1'b1;
            end else begin
                starve_d = '0;
            end
        end
    end

    // Starvation streak register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    // Winner: strict data-port priority.
    always_comb begin
        grant_dm = bus.dm_req;
    end
`endif

    // Response fires in the last WAIT cycle; writes return zero data.
    assign resp_fire = (state_q == WAIT) && (cnt_q == '0);
    assign resp_data = wr_q ? '0 : bus.mem_rdata;

    // Next-state and registered memory command generation.
    always_comb begin
        state_d     = state_q;
        owner_dm_d  = owner_dm_q;
        wr_d        = wr_q;
        cnt_d       = cnt_q;
        mem_en_d    = 1'b0;
        mem_wr_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    owner_dm_d  = grant_dm;
                    wr_d        = grant_dm & bus.dm_wr;
                    mem_en_d    = 1'b1;
                    mem_wr_d    = grant_dm & bus.dm_wr;
                    mem_addr_d  = grant_dm ? bus.dm_addr : bus.if_addr;
                    mem_wdata_d = grant_dm ? bus.dm_wdata : '0;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = CNT_LOAD;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, latched grant and memory command registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_dm_q  <= 1'b0;
            wr_q        <= 1'b0;
            cnt_q       <= '0;
            mem_en_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_dm_q  <= owner_dm_d;
            wr_q        <= wr_d;
            cnt_q       <= cnt_d;
            mem_en_q    <= mem_en_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Per-port response registers: index 0 = fetch, 1 = data.
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        logic              ack_q, ack_d;
        logic [DATA_W-1:0] rdata_q, rdata_d;

        // Ack only the owner; the other port's rdata holds its last value.
        always_comb begin
            ack_d   = resp_fire && (owner_dm_q == (gi == 1));
            rdata_d = ack_d ? resp_data : rdata_q;
        end

        // Registered ack pulse and read data.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ack_q   <= 1'b0;
                rdata_q <= '0;
            end else begin
                ack_q   <= ack_d;
                rdata_q <= rdata_d;
            end
        end
    end

    assign bus.if_ack    = g_port[0].ack_q;
    assign bus.if_rdata  = g_port[0].rdata_q;
    assign bus.dm_ack    = g_port[1].ack_q;
    assign bus.dm_rdata  = g_port[1].rdata_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates a single-port unified memory between the fetch stage (instruction reads) and the memory stage (data reads and writes).
- Sequences each access through a fixed-latency memory and returns data with a one-cycle ack pulse.
- The pipeline holds the requesting stage while that stage's req is high and its ack has not yet arrived.
- The data port has priority, because it carries the older instruction.

Parameters:
ADDR_W, 16, address width
DATA_W, 16, data width
LATENCY, 4, cycles from the mem_en cycle to the cycle mem_rdata is valid; must be >= 1
STARVE_LIMIT, 3, consecutive data grants allowed while if_req waits (used only with the optional feature)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
if_req  input  1  fetch read request; held high until if_ack
if_addr  input  ADDR_W  fetch address; stable while if_req is high
if_rdata  output  DATA_W  fetch read data; valid while if_ack is high
if_ack  output  1  one-cycle completion pulse for the fetch port
dm_req  input  1  data request; held high until dm_ack
dm_wr  input  1  1 = write, 0 = read
dm_addr  input  ADDR_W  data address
dm_wdata  input  DATA_W  write data
dm_rdata  output  DATA_W  data read result; valid while dm_ack is high
dm_ack  output  1  one-cycle completion pulse for the data port
mem_en  output  1  one-cycle memory command strobe
mem_wr  output  1  memory write enable; qualified by mem_en
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_rdata  input  DATA_W  memory read data; valid LATENCY cycles after mem_en
busy  output  1  high when the state is not IDLE

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; latched owner, address and data cleared.
  - An in-flight transaction is abandoned; no ack is issued for it.
  - A mem_rdata that returns after reset is ignored.
- States: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE, cycle T, at least one request high:
  - Choose an owner: dm wins if dm_req=1, else if.
  - Latch the owner and the winner's addr, wr and wdata; a fetch is always a read.
  - Go to ISSUE.
  - Inputs that change after T are ignored until the next grant.
- ISSUE, cycle T+1:
  - Registered outputs drive mem_en=1 with mem_wr, mem_addr and mem_wdata from the latched values.
  - Load the latency counter with LATENCY-1; go to WAIT.
  - mem_en is high for exactly this one cycle per transaction.
- WAIT:
  - Decrement the counter each cycle.
  - In cycle T+1+LATENCY (counter = 0), capture mem_rdata and go to RESP.
  - The counter is $clog2(LATENCY+1) bits wide and never wraps.
- RESP, cycle T+2+LATENCY:
  - The owner's ack=1 for one cycle.
  - The owner's rdata = the captured data for a read; 0 for a write.
  - The other port's ack stays 0; the other rdata output holds its last value.
  - Go to IDLE.
- Request-to-ack latency is LATENCY+2 cycles for reads and writes alike.
- Back-to-back: a waiting port's request is granted in the IDLE cycle after RESP, so grants are spaced LATENCY+3 cycles apart.
- Requester rule: req must be low in the cycle after ack unless it is a new request. The arbiter never samples req during ISSUE, WAIT or RESP.
- if_ack and dm_ack are never high in the same cycle.
- mem_en is never asserted outside ISSUE.
- busy = (state != IDLE).

Optional Feature:
- Macro: ARB_STARVE_GUARD_EN.
- Defined:
  - A counter tracks consecutive dm grants made while if_req=1.
  - When it reaches STARVE_LIMIT, the next grant goes to if even if dm_req=1.
  - The counter clears on any if grant, and on any grant made while if_req=0.
  - Its reset value is 0.
- Undefined: strict dm priority; the counter logic is absent.

Test Plan:
- Fetch read: preload mem[0x0010]=0xBEEF, LATENCY=4, if_req at cycle 0 -> mem_en at cycle 1 with addr 0x0010; if_ack=1 and if_rdata=0xBEEF at cycle 6 only; busy high for cycles 1-6.
- Contention: if_req and dm_req (read of 0x0020 = 0x1234) both rise at cycle 0 -> dm_ack with 0x1234 at cycle 6; fetch granted at cycle 7; if_ack at cycle 13; never both acks high together.
- Write then read: dm write of 0xA5A5 to 0x0030 acked at cycle 6 with dm_rdata=0 -> a following dm read of 0x0030 returns 0xA5A5; mem_wr=1 only in the write's ISSUE cycle.
- Reset mid-op: rst_n=0 for one cycle at cycle 3 of a read -> all outputs 0 immediately; no ack ever issued for that read; a new request afterwards completes in LATENCY+2 cycles.
- Starvation, macro defined, STARVE_LIMIT=3: if_req held high, dm_req re-raised after every ack -> grant order dm, dm, dm, if, dm, ...; without the macro, if is never acked while dm_req stays saturated.
- LATENCY=1: a read is acked 3 cycles after req; the counter does not underflow (mem_en count equals ack count over 100 random requests).
